// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for the hi/lo multiply-divide sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);
  localparam logic [MD_WIDTH-1:0] MD_DIV0_QUO = '1;
  function automatic logic md_is_signed(input md_op_e o);
    return o == MD_MULT || o == MD_DIV;
  endfunction
  function automatic logic md_is_div(input md_op_e o);
    return o == MD_DIV || o == MD_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one combinational shift-add (multiply) or restoring-subtract (divide) step on {acc, opnd}
//   is_div         : 1 = restoring divide step, 0 = shift-add multiply step
//   acc, opnd      : current upper / lower halves of the working register
//   m              : multiplicand (multiply) or divisor (divide) magnitude
//   acc_n, opnd_n  : halves after one step
module muldiv_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] opnd_n
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic           ge;
  always_comb begin
    sum    = {1'b0, acc} + (opnd[0] ? {1'b0, m} : '0);
    sh     = {acc, opnd[WIDTH-1]};
    ge     = sh >= {1'b0, m};
    // when ge holds the true difference is below 2^WIDTH, so WIDTH-bit subtraction is exact
    acc_n  = is_div ? (ge ? sh[WIDTH-1:0] - m : sh[WIDTH-1:0]) : sum[WIDTH:1];
    opnd_n = is_div ? {opnd[WIDTH-2:0], ge} : {sum[0], opnd[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine owning the architectural hi/lo registers
//   clk, reset          : clock, asynchronous active-high reset
//   start, op, op1, op2 : launch request, opcode and operands (sampled only in IDLE)
//   write_hi, write_lo  : MTHI/MTLO requests loading wdata (IDLE only, start wins)
//   read_hilo           : MFHI/MFLO request, used only for stall generation
//   hi, lo              : architectural hi/lo
//   busy, done, stall   : operation in flight, result-written pulse, pipeline hold
// Optional MULDIV_FAST_MUL_EN: multiplies skip iteration and form the product in one cycle.
// WIDTH must equal muldiv_pkg::MD_WIDTH, which sizes the counter and div-by-zero constant.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             write_hi,
  input  logic             write_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  md_state_e           state_q, state_d;
  md_op_e              op_q, op_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    acc_q, acc_d, opnd_q, opnd_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic                sa_q, sa_d, sb_q, sb_d, sgn_q, sgn_d, done_q, done_d;
  logic [WIDTH-1:0]    acc_n, opnd_n, mag1, mag2, quo, rem;
  logic [2*WIDTH-1:0]  prod, res;
  logic                sgn_in, neg;
  muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (md_is_div(op_q)),
    .acc    (acc_q),
    .opnd   (opnd_q),
    .m      (m_q),
    .acc_n  (acc_n),
    .opnd_n (opnd_n)
  );
  always_comb begin
    sgn_in = md_is_signed(md_op_e'(op));
    mag1   = (sgn_in && op1[WIDTH-1]) ? -op1 : op1;
    mag2   = (sgn_in && op2[WIDTH-1]) ? -op2 : op2;
    neg    = sgn_q && (sa_q ^ sb_q);
`ifdef MULDIV_FAST_MUL_EN
    prod   = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, m_q};
`else
    prod   = {acc_q, opnd_q};
`endif
    quo    = neg ? -opnd_q : opnd_q;
    rem    = (sgn_q && sa_q) ? -acc_q : acc_q;
    // divide by zero reports an all-ones quotient regardless of sign
    res    = md_is_div(op_q) ? {rem, (m_q == '0) ? MD_DIV0_QUO : quo} : (neg ? -prod : prod);
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    m_d     = m_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // multiplication commutes, so both ops load dividend/multiplicand into opnd and divisor/multiplier into m
          op_d   = md_op_e'(op);
          sgn_d  = sgn_in;
          sa_d   = op1[WIDTH-1];
          sb_d   = op2[WIDTH-1];
          opnd_d = mag1;
          m_d    = mag2;
          acc_d  = '0;
          cnt_d  = '0;
`ifdef MULDIV_FAST_MUL_EN
          state_d = md_is_div(md_op_e'(op)) ? S_ITER : S_FIX;
`else
          state_d = S_ITER;
`endif
        end else begin
          hi_d = write_hi ? wdata : hi_q;
          lo_d = write_lo ? wdata : lo_q;
        end
      end
      S_ITER: begin
        acc_d   = acc_n;
        opnd_d  = opnd_n;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == MD_CNT_W'(WIDTH-1)) ? S_FIX : S_ITER;
      end
      S_FIX: begin
        {hi_d, lo_d} = res;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      m_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      m_q     <= m_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = state_q != S_IDLE;
  assign done  = done_q;
  assign stall = busy && (read_hilo || write_hi || write_lo || start);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op1 = '0, op2 = '0, wdata = '0;
  logic        write_hi = 1'b0, write_lo = 1'b0, read_hilo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;
  int          checks = 0, failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  muldiv_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .write_hi  (write_hi),
    .write_lo  (write_lo),
    .wdata     (wdata),
    .read_hilo (read_hilo),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return {32'd0, a} * {32'd0, b};
      2'd2: return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic wr, input string tag);
    logic [63:0] r;
    int n, lat;
    r = model(o, a, b);
`ifdef MULDIV_FAST_MUL_EN
    lat = o[1] ? 33 : 1;
`else
    lat = 33;
`endif
    @(negedge clk);
    op = o; op1 = a; op2 = b; start = 1'b1;
    write_hi = wr; write_lo = wr; wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    op1 = $urandom; op2 = $urandom;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    {m_hi, m_lo} = r;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_hilo"}, {hi, lo}, r);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask
  initial begin
    int n, bad, dn;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, stall}, 64'd0);
    @(negedge clk);
    write_hi = 1'b1; write_lo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    write_hi = 1'b0; write_lo = 1'b0;
    m_hi = 32'hA5A5_A5A5; m_lo = 32'hA5A5_A5A5;
    chk("mt_both", {hi, lo}, {m_hi, m_lo});
    run_op(2'd3, 32'd100, 32'd7, 1'b1, "divu_wr");
    chk("divu_val", {hi, lo}, {32'd2, 32'd14});
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
    chk("mult_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    chk("div_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd5, 32'd0, 1'b0, "div0_pos");
    chk("div0_val", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(2'd2, 32'hFFFF_FFFB, 32'd0, 1'b0, "div0_neg");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    chk("ovf_val", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    @(negedge clk);
    op = 2'd3; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    read_hilo = 1'b1; write_hi = 1'b1; wdata = 32'h1234_5678;
    #1 chk("stall_rd", 64'(stall), 64'd1);
    n = 0; bad = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (!done && (!stall || hi !== m_hi)) bad++;
    end
    chk("stall_hold", 64'(bad), 64'd0);
    chk("stall_drop", 64'(stall), 64'd0);
    m_hi = 32'd1; m_lo = 32'd333;
    chk("stall_hilo", {hi, lo}, {m_hi, m_lo});
    read_hilo = 1'b0; write_hi = 1'b0;
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "pre_rst");
    @(negedge clk);
    op = 2'd2; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("arst", {hi, lo, 31'd0, busy}, 96'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("arst_nodone", 64'(dn), 64'd0);
    run_op(2'd2, 32'd77, 32'd5, 1'b0, "post_rst");
    for (int i = 0; i < 40; i++) run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), "rnd");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for MIPS MULT/MULTU/DIV/DIVU. Owns the architectural hi/lo registers and takes that role away from the single-cycle alu.
- Sits beside alu in the execute stage.
- Iterates radix-2 shift-add multiply and restoring divide on operand magnitudes, then applies a sign-fix cycle.
- Drives a stall to the pipeline for any hi/lo access while it is busy.

Parameters:
- WIDTH, 32: operand width. Iteration count equals WIDTH; hi/lo are each WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch an operation; sampled only in IDLE.
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with start.
- op1  in  WIDTH  multiplicand / dividend (rs); sampled with start.
- op2  in  WIDTH  multiplier / divisor (rt); sampled with start.
- write_hi  in  1  MTHI request.
- write_lo  in  1  MTLO request.
- wdata  in  WIDTH  data for MTHI/MTLO.
- read_hilo  in  1  MFHI/MFLO request in the current cycle.
- hi  out  WIDTH  architectural hi register.
- lo  out  WIDTH  architectural lo register.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse after hi/lo take a result.
- stall  out  1  pipeline hold request.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset is asynchronous, active-high, named reset.
  - On reset: state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 at edge E0: latch op, |op1|, |op2|, both sign bits, signed flag; go to ITER. Magnitudes apply only to signed ops; unsigned ops use raw operands.
  - Otherwise, write_hi/write_lo load wdata into hi/lo at that edge. Both may assert together.
  - start has priority over write_hi/write_lo in the same cycle; the writes are dropped.
- ITER (edges E1..E32, counter 0..WIDTH-1):
  - Multiply: one 2*WIDTH-bit shift-add step per edge.
  - Divide: one restore step per edge, producing one quotient bit (MSB first).
  - Counter reaching WIDTH-1 -> FIX.
- FIX (edge E33):
  - Signed multiply: negate the 64-bit product if the signs differed.
  - Signed divide: negate the quotient if the signs differed; the remainder takes the dividend's sign.
  - Write {hi,lo}; go to IDLE.
- Outputs over time:
  - busy=1 from after E0 through E33.
  - done=1 for the single cycle after E33.
  - Latency: result visible on hi/lo 33 edges after the start edge.
- Divide by zero:
  - No exception.
  - lo = all ones; hi = dividend with sign-fix applied. Signed dividend −5 gives hi = −5.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- stall = busy & (read_hilo | write_hi | write_lo | start). This holds the requester until done.
- While busy: start/write_hi/write_lo are ignored (never silently merged); hi/lo keep their old values until FIX.
- Reset mid-operation: immediate return to IDLE, hi=lo=0, no done pulse.
- Operands are captured at E0; changes to op1/op2 afterwards have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the full product combinationally from the latched operands and go IDLE→FIX directly.
  - Result written at E1; busy high only between E0 and E1; done the cycle after E1.
  - DIV timing unchanged.
- Undefined: multiply uses the 32-step iterative path described above.

Decomposition:
- Package muldiv_pkg:
  - op encoding enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - state enum (S_IDLE, S_ITER, S_FIX).
  - counter width constant $clog2(WIDTH).
  - div-by-zero quotient constant.
- Sub-module muldiv_iter_step:
  - Purely combinational one-step shift-add / restoring-subtract on {acc, operand}.
  - Keeps the FSM module to control and registers.

Test Plan:
- MULT op1=0xFFFFFFFD (−3), op2=7 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- DIVU op1=100, op2=7 -> lo=14, hi=2. DIV op1=−7, op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV op1=5, op2=0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU busy, read_hilo=1 at E5 -> stall=1 through E33; stall drops in the done cycle with new hi/lo. Also: write_hi while busy -> hi unchanged.
- Reset asserted asynchronously mid-cycle after E10 of a DIV -> busy/hi/lo=0 immediately; no done; next start behaves normally.
- IDLE: write_hi=1, write_lo=1, wdata=0xA5A5A5A5 -> both updated next edge. Same cycle with start=1 -> writes dropped, operation launched.
